game_logic: RTL and testbench
=============================

// Module: game_logic
// PURPOSE
// - Per-frame Breakout game state: paddle X position plus one bouncing ball, driven by two buttons.
// - Sits between the input debouncers and the VGA renderer.
// - The renderer pulses START_UPDATE once per frame (vblank); the block runs a short update sequence and holds results stable between updates.
// PARAMETERS
// - SCREEN_W 800 : visible width (px)
// - SCREEN_H 600 : visible height (px)
// - PADDLE_W 96 : paddle width (px)
// - PADDLE_Y 560 : paddle top row (px)
// - PADDLE_H 8 : paddle height (px)
// - PADDLE_SPEED 4 : paddle px per update
// - BALL_SIZE 8 : ball square edge (px)
// - BALL_SPEED 2 : ball px per update per axis
// PORTS
// - CLK in 1 : system clock; all state on rising edge
// - RESET_N in 1 : asynchronous, active-low reset
// - START_UPDATE in 1 : frame-update request; level may stay high many cycles
// - BTN_LEFT in 1 : move paddle left (synchronous, debounced)
// - BTN_RIGHT in 1 : move paddle right
// - PADDLE_X_PIXEL out 10 : paddle left edge X
// - BALL_X_PIXEL out 10 : ball left edge X
// - BALL_Y_PIXEL out 10 : ball top edge Y
// - BUSY out 1 : update sequence in progress
// - BALL_LOST out 1 : 1-cycle pulse when ball leaves the bottom edge
// BEHAVIOUR
// - Reset values: PADDLE_X = (SCREEN_W-PADDLE_W)/2 = 352; BALL_X = 396; BALL_Y = 400; vx = +BALL_SPEED; vy = -BALL_SPEED (up); BUSY = 0; BALL_LOST = 0.
// - START_UPDATE is edge-detected with a registered copy. Only a 0->1 transition starts an update, so a held level yields exactly one update.
// - A rising edge seen while BUSY=1 is dropped.
// - FSM: IDLE -> PADDLE -> BALL_X -> BALL_Y -> IDLE, one cycle per state.
// - BUSY = 1 in PADDLE, BALL_X and BALL_Y. Outputs settle 3 cycles after the edge is detected.
// - PADDLE state, buttons sampled in this state:
//   - left only: X -= PADDLE_SPEED, saturating at 0.
//   - right only: X += PADDLE_SPEED, saturating at SCREEN_W-PADDLE_W (704).
//   - both or neither: X unchanged.
// - BALL_X state:
//   - nx = X + vx.
//   - nx <= 0: X = 0, vx = +BALL_SPEED.
//   - nx >= SCREEN_W-BALL_SIZE: X = 792, vx = -BALL_SPEED.
//   - otherwise X = nx.
//   - Use 11-bit signed intermediates; no wrap-around.
// - BALL_Y state:
//   - ny = Y + vy.
//   - ny <= 0: Y = 0, vy = +BALL_SPEED.
//   - Paddle hit when vy > 0, ny+BALL_SIZE >= PADDLE_Y, ny < PADDLE_Y+PADDLE_H, and ball/paddle X ranges overlap (inclusive).
//     Response: Y = PADDLE_Y-BALL_SIZE (552), vy = -BALL_SPEED.
//   - ny >= SCREEN_H: ball restored to its reset position and velocity; BALL_LOST pulses one cycle.
//   - otherwise Y = ny.
// - Paddle is updated before the ball, so the collision check uses the new paddle X.
// - RESET_N low mid-sequence: every register returns to its reset value at once and FSM goes to IDLE. A START_UPDATE level held through reset release does not trigger an update.
// CONFIGURATION
// - GAME_LOGIC_AUTOPLAY_EN defined: the buttons are ignored in the PADDLE state.
//   - Paddle centre steps PADDLE_SPEED toward ball centre; no step when within PADDLE_SPEED.
//   - Same saturation limits.
// - Not defined: button control exactly as in BEHAVIOUR.
// TESTING
// - Reset release, no stimulus -> PADDLE_X_PIXEL=352, BALL=(396,400), BUSY=0.
// - START_UPDATE high 5 cycles, BTN_LEFT held 4000 cycles -> exactly one update: PADDLE_X=348; BALL=(398,398).
// - BTN_LEFT held over 100 update pulses -> PADDLE_X reaches 0 and stays 0.
// - BTN_RIGHT over 100 pulses -> PADDLE_X saturates at 704. Both buttons -> unchanged.
// - Ball walks to x=792 -> vx flips negative next update. Ball at y=552 above paddle -> vy flips, Y=552.
// - Paddle moved away, ball falls past y=600 -> BALL_LOST pulse, ball back to (396,400).
// - Second pulse during BUSY -> ignored.
// - RESET_N low mid-update -> reset values.

Source files
------------

// File: rtl/game_logic.sv
// Per-frame Breakout state: paddle X plus one bouncing ball, stepped once per START_UPDATE edge.
// Optional macro GAME_LOGIC_AUTOPLAY_EN makes the paddle track the ball and ignore the buttons.
module game_logic #(
  parameter int unsigned ScreenW     = 800,
  parameter int unsigned ScreenH     = 600,
  parameter int unsigned PaddleW     = 96,
  parameter int unsigned PaddleY     = 560,
  parameter int unsigned PaddleH     = 8,
  parameter int unsigned PaddleSpeed = 4,
  parameter int unsigned BallSize    = 8,
  parameter int unsigned BallSpeed   = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_update_i,
  input  logic       btn_left_i,
  input  logic       btn_right_i,
  output logic [9:0] paddle_x_pixel_o,
  output logic [9:0] ball_x_pixel_o,
  output logic [9:0] ball_y_pixel_o,
  output logic       busy_o,
  output logic       ball_lost_o
);

  typedef enum logic [1:0] {StIdle, StPaddle, StBallX, StBallY} state_e;

  localparam logic [9:0] PadInit   = 10'((ScreenW - PaddleW) / 2);
  localparam logic [9:0] PadMax    = 10'(ScreenW - PaddleW);
  localparam logic [9:0] PadStep   = 10'(PaddleSpeed);
  localparam logic [9:0] BallXInit = 10'((ScreenW - BallSize) / 2);
  localparam logic [9:0] BallYInit = 10'(ScreenH * 2 / 3);

  localparam logic signed [10:0] BallStep  = 11'(BallSpeed);
  localparam logic signed [10:0] BallXMax  = 11'(ScreenW - BallSize);
  localparam logic signed [10:0] ScreenHS  = 11'(ScreenH);
  localparam logic signed [10:0] PadTopS   = 11'(PaddleY);
  localparam logic signed [10:0] PadBotS   = 11'(PaddleY + PaddleH);
  localparam logic signed [10:0] BallSzS   = 11'(BallSize);
  localparam logic signed [10:0] BallRestS = 11'(PaddleY - BallSize);

  state_e     state_q, state_d;
  logic       start_q;
  logic [9:0] paddle_x_q, paddle_x_d;
  logic [9:0] ball_x_q, ball_x_d;
  logic [9:0] ball_y_q, ball_y_d;
  logic       vx_neg_q, vx_neg_d;
  logic       vy_neg_q, vy_neg_d;
  logic       ball_lost_q, ball_lost_d;

  logic              start_rise;
  logic              move_left, move_right;
  logic [9:0]        paddle_moved;
  logic signed [10:0] nx, ny;
  logic              x_overlap, paddle_hit;

  // start_q resets high so a level held through reset release is not seen as an edge.
  assign start_rise = start_update_i & ~start_q;

`ifdef GAME_LOGIC_AUTOPLAY_EN
  logic [10:0] pad_centre, ball_centre;
  logic        unused_btn;

  assign unused_btn  = ^{btn_left_i, btn_right_i};
  assign pad_centre  = {1'b0, paddle_x_q} + 11'(PaddleW / 2);
  assign ball_centre = {1'b0, ball_x_q} + 11'(BallSize / 2);
  assign move_right  = ball_centre > (pad_centre + 11'(PaddleSpeed));
  assign move_left   = (ball_centre + 11'(PaddleSpeed)) < pad_centre;
`else
  assign move_left  = btn_left_i & ~btn_right_i;
  assign move_right = btn_right_i & ~btn_left_i;
`endif

  always_comb begin
    paddle_moved = paddle_x_q;
    if (move_left) begin
      paddle_moved = (paddle_x_q < PadStep) ? 10'd0 : paddle_x_q - PadStep;
    end else if (move_right) begin
      paddle_moved = (paddle_x_q > PadMax - PadStep) ? PadMax : paddle_x_q + PadStep;
    end
  end

  // Signed intermediates keep a step past the edge from wrapping.
  assign nx = $signed({1'b0, ball_x_q}) + (vx_neg_q ? -BallStep : BallStep);
  assign ny = $signed({1'b0, ball_y_q}) + (vy_neg_q ? -BallStep : BallStep);

  // Inclusive X overlap of ball and paddle, using the paddle position from this update.
  assign x_overlap = ({1'b0, ball_x_q} <= {1'b0, paddle_x_q} + 11'(PaddleW - 1)) &&
                     ({1'b0, ball_x_q} + 11'(BallSize - 1) >= {1'b0, paddle_x_q});

  assign paddle_hit = ~vy_neg_q && (ny + BallSzS >= PadTopS) && (ny < PadBotS) && x_overlap;

  always_comb begin
    state_d     = state_q;
    paddle_x_d  = paddle_x_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    vx_neg_d    = vx_neg_q;
    vy_neg_d    = vy_neg_q;
    ball_lost_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_rise) state_d = StPaddle;
      end
      StPaddle: begin
        paddle_x_d = paddle_moved;
        state_d    = StBallX;
      end
      StBallX: begin
        if (nx <= 11'sd0) begin
          ball_x_d = 10'd0;
          vx_neg_d = 1'b0;
        end else if (nx >= BallXMax) begin
          ball_x_d = BallXMax[9:0];
          vx_neg_d = 1'b1;
        end else begin
          ball_x_d = nx[9:0];
        end
        state_d = StBallY;
      end
      StBallY: begin
        if (ny <= 11'sd0) begin
          ball_y_d = 10'd0;
          vy_neg_d = 1'b0;
        end else if (paddle_hit) begin
          ball_y_d = BallRestS[9:0];
          vy_neg_d = 1'b1;
        end else if (ny >= ScreenHS) begin
          ball_x_d    = BallXInit;
          ball_y_d    = BallYInit;
          vx_neg_d    = 1'b0;
          vy_neg_d    = 1'b1;
          ball_lost_d = 1'b1;
        end else begin
          ball_y_d = ny[9:0];
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      start_q     <= 1'b1;
      paddle_x_q  <= PadInit;
      ball_x_q    <= BallXInit;
      ball_y_q    <= BallYInit;
      vx_neg_q    <= 1'b0;
      vy_neg_q    <= 1'b1;
      ball_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_update_i;
      paddle_x_q  <= paddle_x_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      vx_neg_q    <= vx_neg_d;
      vy_neg_q    <= vy_neg_d;
      ball_lost_q <= ball_lost_d;
    end
  end

  assign paddle_x_pixel_o = paddle_x_q;
  assign ball_x_pixel_o   = ball_x_q;
  assign ball_y_pixel_o   = ball_y_q;
  assign busy_o           = (state_q != StIdle);
  assign ball_lost_o      = ball_lost_q;

endmodule

// File: tb/tb_game_logic.sv
// Directed bench for game_logic: vector table for single updates plus long hand-computed sequences.
module tb_game_logic;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       bl;
  logic       br;
  logic [9:0] px;
  logic [9:0] bx;
  logic [9:0] by;
  logic       busy;
  logic       lost;

  int n_cmp = 0;
  int n_bad = 0;
  int busy_cyc;
  logic lost_seen;
  int busy_total;

  typedef struct {
    logic l;
    logic r;
    int   px;
    int   bx;
    int   by;
  } vec_t;

  vec_t vecs [6];

  game_logic dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .start_update_i   (start),
    .btn_left_i       (bl),
    .btn_right_i      (br),
    .paddle_x_pixel_o (px),
    .ball_x_pixel_o   (bx),
    .ball_y_pixel_o   (by),
    .busy_o           (busy),
    .ball_lost_o      (lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge where results (and any lost pulse) are visible.
  task automatic update(input logic l, input logic r);
    bl = l;
    br = r;
    start = 1'b1;
    busy_cyc = 0;
    lost_seen = 1'b0;
    @(negedge clk);
    start = 1'b0;
    if (busy) busy_cyc++;
    repeat (3) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (lost) lost_seen = 1'b1;
    end
  endtask

  initial begin
    vecs[0] = '{l: 1'b1, r: 1'b0, px: 348, bx: 398, by: 398};
    vecs[1] = '{l: 1'b1, r: 1'b0, px: 344, bx: 400, by: 396};
    vecs[2] = '{l: 1'b0, r: 1'b1, px: 348, bx: 402, by: 394};
    vecs[3] = '{l: 1'b1, r: 1'b1, px: 348, bx: 404, by: 392};
    vecs[4] = '{l: 1'b0, r: 1'b0, px: 348, bx: 406, by: 390};
    vecs[5] = '{l: 1'b0, r: 1'b1, px: 352, bx: 408, by: 388};

    rst_n = 1'b0;
    start = 1'b0;
    bl = 1'b0;
    br = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_paddle_x", px, 352);
    check("reset_ball_x", bx, 396);
    check("reset_ball_y", by, 400);
    check("reset_busy", busy, 0);
    check("reset_lost", lost, 0);

    for (int i = 0; i < 6; i++) begin
      update(vecs[i].l, vecs[i].r);
      check($sformatf("vec%0d_paddle_x", i), px, vecs[i].px);
      check($sformatf("vec%0d_ball_x", i), bx, vecs[i].bx);
      check($sformatf("vec%0d_ball_y", i), by, vecs[i].by);
      check($sformatf("vec%0d_lost", i), lost_seen, 0);
      check($sformatf("vec%0d_busy_cycles", i), busy_cyc, 3);
    end

    // Level held 5 cycles with left held for 4000 cycles: exactly one update.
    bl = 1'b1;
    br = 1'b0;
    do_reset();
    start = 1'b1;
    busy_total = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (i == 4) start = 1'b0;
      if (busy) busy_total++;
    end
    check("held_level_busy_cycles", busy_total, 3);
    check("held_level_paddle_x", px, 348);
    check("held_level_ball_x", bx, 398);
    check("held_level_ball_y", by, 398);

    // Left saturation.
    do_reset();
    repeat (88) update(1'b1, 1'b0);
    check("left_88_paddle_x", px, 0);
    repeat (12) update(1'b1, 1'b0);
    check("left_100_paddle_x", px, 0);
    check("left_100_ball_x", bx, 596);
    check("left_100_ball_y", by, 200);

    // Right saturation, then both buttons.
    do_reset();
    repeat (88) update(1'b0, 1'b1);
    check("right_88_paddle_x", px, 704);
    repeat (12) update(1'b0, 1'b1);
    check("right_100_paddle_x", px, 704);
    update(1'b1, 1'b1);
    check("both_paddle_x", px, 704);
    check("both_ball_x", bx, 598);
    check("both_ball_y", by, 198);

    // Right wall bounce, top bounce, then paddle catch.
    do_reset();
    repeat (198) update(1'b0, 1'b0);
    check("wall_ball_x", bx, 792);
    check("wall_ball_y", by, 4);
    update(1'b0, 1'b0);
    check("wall_next_ball_x", bx, 790);
    check("wall_next_ball_y", by, 2);
    update(1'b1, 1'b0);
    check("top_ball_y", by, 0);
    check("top_ball_x", bx, 788);
    repeat (29) update(1'b1, 1'b0);
    check("catch_paddle_x", px, 232);
    check("catch_pre_ball_x", bx, 730);
    check("catch_pre_ball_y", by, 58);
    repeat (247) update(1'b0, 1'b0);
    check("catch_ball_y", by, 552);
    check("catch_ball_x", bx, 236);
    check("catch_lost", lost_seen, 0);
    update(1'b0, 1'b0);
    check("catch_up_ball_y", by, 550);
    check("catch_up_ball_x", bx, 234);

    // Paddle away: ball falls out and is restored.
    do_reset();
    repeat (499) update(1'b0, 1'b0);
    check("fall_pre_ball_y", by, 598);
    check("fall_pre_ball_x", bx, 190);
    check("fall_pre_lost", lost_seen, 0);
    update(1'b0, 1'b0);
    check("fall_lost_pulse", lost_seen, 1);
    check("fall_ball_x", bx, 396);
    check("fall_ball_y", by, 400);
    check("fall_paddle_x", px, 352);
    @(negedge clk);
    check("fall_lost_one_cycle", lost, 0);
    update(1'b0, 1'b0);
    check("fall_restart_ball_x", bx, 398);
    check("fall_restart_ball_y", by, 398);

    // Second rising edge during busy is dropped.
    bl = 1'b0;
    br = 1'b0;
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_total = busy ? 1 : 0;
    @(negedge clk);
    start = 1'b1;
    if (busy) busy_total++;
    @(negedge clk);
    start = 1'b0;
    if (busy) busy_total++;
    repeat (10) begin
      @(negedge clk);
      if (busy) busy_total++;
    end
    check("busy_drop_cycles", busy_total, 3);
    check("busy_drop_ball_x", bx, 398);
    check("busy_drop_ball_y", by, 398);

    // Reset mid-update with start held through release.
    do_reset();
    bl = 1'b1;
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midreset_pre_paddle_x", px, 348);
    rst_n = 1'b0;
    #1;
    check("midreset_paddle_x", px, 352);
    check("midreset_ball_x", bx, 396);
    check("midreset_ball_y", by, 400);
    check("midreset_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    busy_total = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy) busy_total++;
    end
    check("held_release_busy_cycles", busy_total, 0);
    check("held_release_paddle_x", px, 352);
    check("held_release_ball_y", by, 400);
    start = 1'b0;
    bl = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
